sequenciador_calculadora: RTL
=============================

# sequenciador_calculadora

Command sequencer that drives the synchronous calculator's `codigo`/`entrada` ports from a buffered valid/ready command stream and captures its `saida` result. It sits between a host and the calculator and turns the calculator's fire-and-forget code interface into a flow-controlled request/result interface. It keeps a shadow accumulator and flags any result that disagrees with it.

## Interface
- `DEPTH`, 4: command FIFO depth; power of two, ≥2.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset. The calculator's active-high `rst` is tied to `~rst_n` at top level.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept. Equals `!full`.
- `cmd_data` in 11: `{codigo[2:0], entrada[7:0]}`.
- `pausa` in 1: freeze issue. Drives NOP and does not pop.
- `calc_codigo` out 3: to calculator `codigo`. Registered.
- `calc_entrada` out 8: to calculator `entrada`. Registered.
- `calc_saida` in 8: from calculator `saida`.
- `res_valid` out 1: one-cycle pulse, result captured.
- `res_data` out 8: captured `saida`.
- `res_code` out 1: 0 = echo (code 000), 1 = accumulator read (code 011).
- `erro` out 1: sticky mismatch flag.
- `busy` out 1: FIFO non-empty or result pipeline non-empty.

## Operation
- Push when `cmd_valid && cmd_ready`. Pop when FIFO is non-empty and `pausa` is low. Push and pop may happen in the same cycle when not full. When full, `cmd_ready` is low even if a pop occurs that cycle.
- Issue: a popped word is registered onto `calc_codigo`/`calc_entrada`. With no pop, drive NOP (`3'b111`, entrada 0). NOP leaves the calculator accumulator unchanged and its output 0.
- Shadow accumulator, 8-bit, mod 256, updated at issue:
  - 001: `+= entrada`
  - 010: `-= entrada`
  - all other codes: unchanged
- Result tracking: a 2-stage tag pipeline follows every issued word and carries `{is_result, res_code, expected}`.
  - Code 000: `is_result` = 1, expected = `entrada`.
  - Code 011: `is_result` = 1, expected = shadow value before this issue.
  - Codes 001/010/1xx: `is_result` = 0.
- Capture: when the stage-2 tag has `is_result` set, register `calc_saida` into `res_data`, set `res_code`, and pulse `res_valid`. If `calc_saida != expected`, set `erro`.
- `erro` clears only on reset.
- Codes 100–110 are forwarded unchanged. They produce no result and do not change the shadow accumulator.

## Timing
- Reset values: `cmd_ready`=1, `calc_codigo`=3'b111, `calc_entrada`=0, `res_valid`=0, `res_data`=0, `res_code`=0, `erro`=0, `busy`=0, FIFO empty, shadow accumulator 0, tags cleared.
- Push at edge a into an empty FIFO with `pausa` low:
  - edge a+1: issue
  - edge a+2: calculator registers
  - edge a+3: capture; `res_valid` is high for the cycle following edge a+3
- Throughput is one command per cycle. Results appear in command order.
- `pausa` stops only issue. In-flight tags still complete. `cmd_ready` follows FIFO occupancy.
- Reset asserted mid-operation flushes the FIFO and tags immediately. In-flight commands are dropped and produce no `res_valid`.

## Structure
- Package `calculadora_pkg` holds:
  - code constants `COD_MOSTRAR`=000, `COD_SOMA`=001, `COD_SUB`=010, `COD_ACC`=011, `COD_NOP`=111
  - `CMD_W`=11
  - the command-field slice positions
- Sub-module `fifo_sincrona`, parameterised by width and depth:
  - count-based full/empty
  - async active-low reset
- The issue register, shadow accumulator, tag pipeline and capture logic stay in the top module.

## Test plan
- Push at reset, no `pausa`: {001,5}, {001,7}, {011,0} on consecutive edges → exactly one `res_valid`, `res_data`=12, `res_code`=1, `erro`=0.
- From reset: {010,3}, {011,0} → `res_data`=253 (wrap-around), `erro`=0.
- Single {000,0xA5} pushed at edge a → `res_valid` only in the cycle after edge a+3, `res_data`=0xA5, `res_code`=0. `calc_codigo` is 111 before and after the issue cycle.
- With `pausa`=1, push 5 commands with DEPTH=4 → `cmd_ready` drops after the 4th push and `calc_codigo` stays 111. Release `pausa` → the 4 results/updates come out in order and `cmd_ready` rises.
- Bench calculator model forces `saida`=0x00 on a {011} read where the shadow value is 0x10 → `res_data`=0x00 and `erro`=1. `erro` stays 1 through later correct results and clears only on `rst_n`=0.
- Assert `rst_n` low for 1 cycle while 3 commands are in flight → no `res_valid` follows, `busy`=0, and all outputs are at their reset values.

Source files
------------

// File: rtl/calculadora_pkg.sv
// Shared constants and types for the calculator command sequencer.
// Command word layout is {codigo[2:0], entrada[7:0]}.
package calculadora_pkg;

  localparam int CMD_W   = 11;
  localparam int COD_W   = 3;
  localparam int ENT_W   = 8;
  localparam int COD_MSB = 10;
  localparam int COD_LSB = 8;
  localparam int ENT_MSB = 7;
  localparam int ENT_LSB = 0;

  localparam logic [COD_W-1:0] COD_MOSTRAR = 3'b000;
  localparam logic [COD_W-1:0] COD_SOMA    = 3'b001;
  localparam logic [COD_W-1:0] COD_SUB     = 3'b010;
  localparam logic [COD_W-1:0] COD_ACC     = 3'b011;
  localparam logic [COD_W-1:0] COD_NOP     = 3'b111;

  // One entry of the result-tracking pipeline.
  typedef struct packed {
    logic             vld;
    logic             is_result;
    logic             code;
    logic [ENT_W-1:0] expected;
  } tag_t;

  function automatic logic [ENT_W-1:0] shadow_next(input logic [COD_W-1:0] cod,
                                                   input logic [ENT_W-1:0] acc,
                                                   input logic [ENT_W-1:0] ent);
    case (cod)
      COD_SOMA: shadow_next = acc + ent;
      COD_SUB:  shadow_next = acc - ent;
      default:  shadow_next = acc;
    endcase
  endfunction

endpackage

// File: rtl/fifo_sincrona.sv
// Synchronous FIFO with count-based full/empty and a combinational head read.
module fifo_sincrona #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push_ok, pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sequenciador_calculadora.sv
// Flow-controlled front end for the synchronous calculator: buffers commands,
// issues one per cycle, captures results and cross-checks a shadow accumulator.
module sequenciador_calculadora
  import calculadora_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd_data,
  input  logic              pausa,
  output logic [COD_W-1:0]  calc_codigo,
  output logic [ENT_W-1:0]  calc_entrada,
  input  logic [ENT_W-1:0]  calc_saida,
  output logic              res_valid,
  output logic [ENT_W-1:0]  res_data,
  output logic              res_code,
  output logic              erro,
  output logic              busy
);

  logic [CMD_W-1:0] head;
  logic             full, empty, pop;
  logic [COD_W-1:0] head_cod;
  logic [ENT_W-1:0] head_ent;
  logic [ENT_W-1:0] shadow;
  tag_t             tag_in;
  tag_t [2:1]       tag_q;

  fifo_sincrona #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid),
    .pop   (pop),
    .din   (cmd_data),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign cmd_ready = !full;
  assign pop       = !empty && !pausa;
  assign head_cod  = head[COD_MSB:COD_LSB];
  assign head_ent  = head[ENT_MSB:ENT_LSB];
  assign busy      = !empty || tag_q[1].vld || tag_q[2].vld;

  // Reads report the shadow value as it stood before this issue.
  always_comb begin
    tag_in           = '0;
    tag_in.vld       = pop;
    tag_in.is_result = pop && (head_cod == COD_MOSTRAR || head_cod == COD_ACC);
    tag_in.code      = (head_cod == COD_ACC);
    tag_in.expected  = (head_cod == COD_ACC) ? shadow : head_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calc_codigo  <= COD_NOP;
      calc_entrada <= '0;
      shadow       <= '0;
      tag_q        <= '0;
    end else begin
      calc_codigo  <= pop ? head_cod : COD_NOP;
      calc_entrada <= pop ? head_ent : '0;
      if (pop) shadow <= shadow_next(head_cod, shadow, head_ent);
      tag_q[1] <= tag_in;
      tag_q[2] <= tag_q[1];
    end
  end

  // Stage 2 lines up with the calculator's registered saida.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_code  <= 1'b0;
      erro      <= 1'b0;
    end else begin
      res_valid <= tag_q[2].is_result;
      if (tag_q[2].is_result) begin
        res_data <= calc_saida;
        res_code <= tag_q[2].code;
        if (calc_saida != tag_q[2].expected) erro <= 1'b1;
      end
    end
  end

endmodule
